// File: rtl/aes_pkg.sv
// Shared AES constants, sequencer state encoding, column slicing and S-box helpers.
// Column c of a state occupies bits [127-32c -: 32]; byte 0 sits at [127:120].
package aes_pkg;

  localparam int unsigned AES_COLS    = 4;
  localparam int unsigned AES_COL_W   = 32;
  localparam int unsigned AES_STATE_W = 128;

  typedef logic [AES_COL_W-1:0]   col_t;
  typedef logic [AES_STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic col_t get_col(input state_t s, input logic [1:0] idx);
    col_t c_out;
    c_out = '0;
    for (int unsigned c = 0; c < AES_COLS; c++) begin
      if (idx == 2'(c)) c_out = s[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W];
    end
    return c_out;
  endfunction

  function automatic state_t set_col(input state_t s, input logic [1:0] idx, input col_t v);
    state_t r;
    r = s;
    for (int unsigned c = 0; c < AES_COLS; c++) begin
      if (idx == 2'(c)) r[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W] = v;
    end
    return r;
  endfunction

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 by repeated squaring; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

endpackage

// File: rtl/aes_subbytes_col.sv
// Four-S-box column SubBytes unit, purely combinational.
// Paired with the sequencer at the round level.
module aes_subbytes_col
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] data_in,
  input  logic                 enc_dec,
  output logic [AES_COL_W-1:0] data_out
);

  always_comb begin
    data_out = '0;
    for (int unsigned b = 0; b < AES_COL_W / 8; b++) begin
      data_out[8*b +: 8] = enc_dec ? sbox_fwd(data_in[8*b +: 8]) : sbox_inv(data_in[8*b +: 8]);
    end
  end

endmodule

// File: rtl/aes_subbytes_col_sequencer.sv
// Serialises a 128-bit AES state through a 32-bit column SubBytes unit,
// one column per cycle, and returns the substituted state over valid/ready.
module aes_subbytes_col_sequencer
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_enc_dec,
  input  logic                   abort,
  output logic [AES_COL_W-1:0]   sb_col_out,
  output logic                   sb_enc_dec,
  input  logic [AES_COL_W-1:0]   sb_col_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  seq_state_e state_q, state_d;
  logic [1:0] col_q, col_d;
  state_t     work_q, work_d;
  logic       mode_q, mode_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          mode_d  = in_enc_dec;
          col_d   = '0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        work_d = set_col(work_q, col_q, sb_col_in);
        col_d  = col_q + 2'd1;
        if (col_q == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = '0;
      end
    endcase
    // Abort beats every transition but leaves the working register untouched.
    if (abort) begin
      state_d = ST_IDLE;
      col_d   = '0;
      work_d  = work_q;
      mode_d  = mode_q;
    end
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      work_q      <= '0;
      mode_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Outside SUB the S-box sees column 0 so its inputs stay quiet.
  assign sb_col_out = get_col(work_q, (state_q == ST_SUB) ? col_q : 2'd0);
  assign sb_enc_dec = mode_q;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_state  = work_q;

endmodule

// File: tb/tb_aes_subbytes_col_sequencer.sv
// Directed bench for the column SubBytes sequencer paired with the column S-box unit.
`timescale 1ns/1ps
module tb_aes_subbytes_col_sequencer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_enc_dec;
  logic         abort;
  logic [31:0]  sb_col_out;
  logic         sb_enc_dec;
  logic [31:0]  sb_col_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int vectors;
  int miscompares;

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  aes_subbytes_col_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .in_enc_dec (in_enc_dec),
    .abort      (abort),
    .sb_col_out (sb_col_out),
    .sb_enc_dec (sb_enc_dec),
    .sb_col_in  (sb_col_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state)
  );

  aes_subbytes_col sbox (
    .data_in  (sb_col_out),
    .enc_dec  (sb_enc_dec),
    .data_out (sb_col_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one state at a negedge; returns #1 after the accepting edge.
  task automatic accept(input string tag, input logic [127:0] s, input logic mode);
    @(negedge clk);
    in_valid   = 1'b1;
    in_state   = s;
    in_enc_dec = mode;
    chk({tag, "_in_ready_pre"}, in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_state   = '0;
    in_enc_dec = 1'b1;
    abort      = 1'b0;
    out_ready  = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_state", out_state, '0);
    chk("rst_sb_col_out", sb_col_out, '0);
    chk("rst_sb_enc_dec", sb_enc_dec, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Forward FIPS-197 round 1, latency and initiation interval
    accept("fwd", FIPS_IN, 1'b1);
    chk("fwd_in_ready_busy", in_ready, 1'b0);
    chk("fwd_col0_drive", sb_col_out, 32'h193de3be);
    chk("fwd_sb_mode", sb_enc_dec, 1'b1);
    @(posedge clk); #1;
    chk("fwd_col1_drive", sb_col_out, 32'ha0f4e22b);
    chk("fwd_valid_e1", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("fwd_valid_e3", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("fwd_valid_e4", out_valid, 1'b1);
    chk("fwd_out_state", out_state, FIPS_OUT);
    chk("fwd_sb_quiet", sb_col_out, 32'hd42711ae);
    @(posedge clk); #1;
    chk("fwd_in_ready_e5", in_ready, 1'b1);
    chk("fwd_valid_e5", out_valid, 1'b0);

    // Inverse round trip
    accept("inv", FIPS_OUT, 1'b0);
    chk("inv_sb_mode", sb_enc_dec, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("inv_valid", out_valid, 1'b1);
    chk("inv_out_state", out_state, FIPS_IN);
    @(posedge clk); #1;

    // Backpressure with all-zero state
    out_ready = 1'b0;
    accept("bp", '0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_state", out_state, {4{32'h63636363}});
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bp_single_hs", out_valid, 1'b0);

    // Mode latched at acceptance
    accept("mode", {4{32'h53535353}}, 1'b1);
    in_enc_dec = 1'b0;
    @(posedge clk); #1;
    chk("mode_sb_mode", sb_enc_dec, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("mode_valid", out_valid, 1'b1);
    chk("mode_out_state", out_state, {4{32'hedededed}});
    @(posedge clk); #1;

    // Abort at column 2
    accept("abort", FIPS_IN, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_col2_drive", sb_col_out, 32'h9ac68d2a);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_hs", out_valid, 1'b0);
    end
    accept("post_abort", FIPS_IN, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("post_abort_valid", out_valid, 1'b1);
    chk("post_abort_state", out_state, FIPS_OUT);
    @(posedge clk); #1;

    // Asynchronous reset while holding DONE
    out_ready = 1'b0;
    accept("arst", FIPS_OUT, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("arst_pre_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_state", out_state, '0);
    chk("arst_sb_mode", sb_enc_dec, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    accept("post_arst", FIPS_IN, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("post_arst_valid", out_valid, 1'b1);
    chk("post_arst_state", out_state, FIPS_OUT);
    @(posedge clk); #1;
    chk("post_arst_ready", in_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
